dm_responder: RTL and testbench

- Memory-side responder for the CPU data-memory interface. It accepts one word-addressed request at a time, carrying address, byte enable and write data. The write data arrives already lane-aligned by the CPU side.
- Performs the byte-masked write and/or the full-word read after a programmable number of wait cycles. Returns data_rdata-style 32-bit words over a valid/ready response channel.
- Sits between the M-stage memory interface and the on-chip data RAM. Stands in for the external testbench memory in standalone simulation.

---
 rtl/dm_pkg.sv | 31 +++
 rtl/dm_byte_merge.sv | 17 +
 rtl/dm_responder.sv | 127 ++++++++++++
 tb/tb_dm_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_e : responder FSM encoding (idle / wait / response)
//   BE_*       : legal non-zero byte-enable patterns
//   be_legal() : 1 when a byte-enable pattern is an accepted access shape
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dm_state_e;

  localparam logic [3:0] BE_W  = 4'b1111;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;

  // Read-only (0000), single byte, aligned half or full word.
  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0000, BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
      default:                                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge of lane-aligned write data into an existing memory word.
//   i_old      : current word from RAM
//   i_wdata    : lane-aligned write data
//   i_byteen   : per-lane select, 1 takes the byte from i_wdata
//   o_new_word : merged word
module dm_byte_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byteen,
  output logic [31:0] o_new_word
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign o_new_word[8*i +: 8] = i_byteen[i] ? i_wdata[8*i +: 8] : i_old[8*i +: 8];
  end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the CPU data-memory interface.
// Accepts one request at a time, performs a byte-masked write and/or full-word
// read LAT cycles after accept, and returns the word over a valid/ready channel.
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready                 : request handshake
//   req_addr, req_byteen, req_wdata     : byte address, lane enables, aligned data
//   rsp_valid/rsp_ready                 : response handshake
//   rsp_rdata, rsp_err                  : resulting word, rejection flag
// Optional: define DM_WRITE_TRACE_EN to print committed writes and rejections.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  if (LAT < 1 || LAT > 15) begin : g_lat_check
    $error("dm_responder: LAT=%0d outside legal range 1..15", LAT);
  end

  dm_state_e          r_state, w_state_d;
  logic [3:0]         r_cnt;
  logic [31:2]        r_addr;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  // Not reset; relies on zero power-up contents.
  logic [31:0]        r_mem [Depth];

  logic               w_accept;
  logic               w_access;
  logic               w_err;
  logic               w_we;
  logic [ADDR_W-1:0]  w_idx;
  logic [31:0]        w_old;
  logic [31:0]        w_new;
  logic               w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^req_addr[1:0];

  assign w_accept = (r_state == StIdle) && req_valid;
  assign w_access = (r_state == StWait) && (r_cnt == 4'd0);

  // The full word address is kept so the range check happens at the access edge.
  assign w_idx = r_addr[ADDR_W+1:2];
  assign w_err = (|(r_addr >> ADDR_W)) || !be_legal(r_be);
  assign w_we  = w_access && !w_err && (r_be != 4'b0000);
  assign w_old = r_mem[w_idx];

  dm_byte_merge u_merge (
    .i_old      (w_old),
    .i_wdata    (r_wdata),
    .i_byteen   (r_be),
    .o_new_word (w_new)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (req_valid)       w_state_d = StWait;
      StWait:  if (r_cnt == 4'd0)   w_state_d = StResp;
      StResp:  if (rsp_ready)       w_state_d = StIdle;
      default:                      w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_cnt   <= 4'(LAT - 1);
        r_addr  <= req_addr[31:2];
        r_be    <= req_byteen;
        r_wdata <= req_wdata;
      end else if (r_state == StWait && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= w_err ? 32'd0 : w_new;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= w_new;
    end
`ifdef DM_WRITE_TRACE_EN
    if (w_we) begin
      $display("@%h: *%h <= %h", $time, {w_idx, 2'b00}, w_new);
    end
    if (w_access && w_err) begin
      $display("DM_ERR @%h addr=%h be=%b", $time, {r_addr, 2'b00}, r_be);
    end
`endif
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LAT    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_byteen = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dm_responder #(
    .ADDR_W (ADDR_W),
    .LAT    (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Stimulus only: issue one request, measure accept-to-valid cycles, take response.
  task automatic xact(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    req_addr = a; req_byteen = be; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset ready/valid/err/rdata got=%b%b%b/%h exp=100/00000000",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(32'h10, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_full got=%h/%b exp=deadbeef/0", rd, er);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL wr_latency got=%0d exp=2", lat);
    end
    xact(32'h10, 4'b0000, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_full got=%h/%b exp=deadbeef/0", rd, er);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL rd_latency got=%0d exp=2", lat);
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] addr_t [6]  = '{32'h12, 32'h13, 32'h3FF8, 32'h3FF8, 32'h3FF8, 32'h3FF8};
    logic [3:0]  be_t   [6]  = '{4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0011};
    logic [31:0] wd_t   [6]  = '{32'h12340000, 32'hAB000000, 32'h000000A5,
                                 32'h00007700, 32'h00990000, 32'h0000C3C3};
    logic [31:0] exp_t  [6]  = '{32'h1234BEEF, 32'hAB34BEEF, 32'h000000A5,
                                 32'h000077A5, 32'h009977A5, 32'h0099C3C3};
    for (int i = 0; i < 6; i++) begin
      xact(addr_t[i], be_t[i], wd_t[i], rd, er, lat);
      n_tests++;
      if (rd !== exp_t[i] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL partial[%0d] be=%b got=%h/%b exp=%h/0", i, be_t[i], rd, er, exp_t[i]);
      end
    end
  endtask

  task automatic test_illegal_be();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(32'h10, 4'b0101, 32'hFFFFFFFF, rd, er, lat);
    n_tests++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL be_0101 got=%h/%b exp=00000000/1", rd, er);
    end
    xact(32'h10, 4'b0110, 32'hFFFFFFFF, rd, er, lat);
    n_tests++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL be_0110 got=%h/%b exp=00000000/1", rd, er);
    end
    // Read with junk write data: must not disturb the word.
    xact(32'h10, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
    n_tests++;
    if (rd !== 32'hAB34BEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL after_illegal got=%h/%b exp=ab34beef/0", rd, er);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(32'h4000, 4'b0000, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_4000 got=%h/%b exp=00000000/1", rd, er);
    end
    xact(32'h3FFC, 4'b0000, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL top_3ffc got=%h/%b exp=00000000/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    req_addr = 32'h10; req_byteen = 4'b0000; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // Second request waits while the first response is stalled.
    req_addr = 32'h3FF8; req_byteen = 4'b0000; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, 32'hAB34BEEF}) begin
        n_fail++;
        $display("FAIL stall[%0d] valid/ready/rdata got=%b%b/%h exp=10/ab34beef",
                 k, rsp_valid, req_ready, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_tests++;
    if ({rsp_valid, req_ready, rsp_rdata} !== {1'b0, 1'b1, 32'hAB34BEEF}) begin
      n_fail++;
      $display("FAIL release valid/ready/rdata got=%b%b/%h exp=01/ab34beef",
               rsp_valid, req_ready, rsp_rdata);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL held_req_accept ready got=%b exp=0", req_ready);
    end
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (rsp_rdata !== 32'h0099C3C3 || rsp_err !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL held_req_rsp got=%h/%b lat=%0d exp=0099c3c3/0 lat=2",
               rsp_rdata, rsp_err, lat);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    @(negedge clk);
    req_addr = 32'h20; req_byteen = 4'b1111; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset valid/ready got=%b%b exp=01", rsp_valid, req_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(32'h20, 4'b0000, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL abandoned_write got=%h/%b exp=00000000/0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_illegal_be();
    test_range();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
